sync_fifo_ctl: RTL and testbench



---
 rtl/sync_fifo_ctl_if.sv | 29 ++
 rtl/sync_fifo_ctl.sv | 146 ++++++++++++++
 tb/tb_sync_fifo_ctl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctl_if.sv
// Producer/consumer bundle for sync_fifo_ctl: write and read handshakes plus status.
// The master side is the surrounding datapath; the slave side is the FIFO itself.
interface sync_fifo_ctl_if #(
    parameter int WIDTH  = 3072,
    parameter int ADDR_W = 2
);
    logic              winc;
    logic [WIDTH-1:0]  wdata;
    logic              wfull;
    logic              wafull;
    logic              rinc;
    logic [WIDTH-1:0]  rdata;
    logic              rvalid;
    logic              rempty;
    logic              raempty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output winc, wdata, rinc,
        input  wfull, wafull, rdata, rvalid, rempty, raempty, count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc,
        output wfull, wafull, rdata, rvalid, rempty, raempty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read, occupancy thresholds,
// sticky overflow/underflow and synchronous flush.
module sync_fifo_ctl #(
    parameter int WIDTH     = 3072,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 3,
    parameter int AEMPTY_TH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    sync_fifo_ctl_if.slave bus
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_ctl: DEPTH must be at least 2");
    end
    if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
        $error("sync_fifo_ctl: ADDR_W must equal ceil(log2(DEPTH))");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_ctl: AFULL_TH out of range 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_ctl: AEMPTY_TH out of range 0..DEPTH-1");
    end

    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   AFULL_CNT  = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   AEMPTY_CNT = (ADDR_W + 1)'(AEMPTY_TH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wfull_q, wfull_d;
    logic              wafull_q, wafull_d;
    logic              rempty_q, rempty_d;
    logic              raempty_q, raempty_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;

    // Acceptance looks only at the registered flags, so a full FIFO never takes a
    // write even when a read frees a slot on the same edge.
    assign wr_acc = bus.winc & ~wfull_q;
    assign rd_acc = bus.rinc & ~rempty_q;

    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
            if (rd_acc) rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  | (bus.winc & wfull_q);
            underflow_d = underflow_q | (bus.rinc & rempty_q);
        end

        wfull_d   = (count_d == FULL_CNT);
        wafull_d  = (count_d >= AFULL_CNT);
        rempty_d  = (count_d == '0);
        raempty_d = (count_d <= AEMPTY_CNT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            wfull_q     <= 1'b0;
            wafull_q    <= 1'b0;
            rempty_q    <= 1'b1;
            raempty_q   <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            wfull_q     <= wfull_d;
            wafull_q    <= wafull_d;
            rempty_q    <= rempty_d;
            raempty_q   <= raempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage has no reset; pointers and count define validity, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr) mem_q[wptr_q] <= bus.wdata;
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.rdata  = rempty_q ? '0 : mem_q[rptr_q];
        assign bus.rvalid = ~rempty_q;
    end else begin : g_std
        logic [WIDTH-1:0] rdata_q;
        logic             rvalid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else if (clr) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) rdata_q <= mem_q[rptr_q];
            end
        end

        assign bus.rdata  = rdata_q;
        assign bus.rvalid = rvalid_q;
    end

    assign bus.wfull     = wfull_q;
    assign bus.wafull    = wafull_q;
    assign bus.rempty    = rempty_q;
    assign bus.raempty   = raempty_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Bench for sync_fifo_ctl: three instances (depth 4 standard, depth 5 standard, depth 4 FWFT)
// driven in lockstep and compared against a queue-based occupancy model.
module tb_sync_fifo_ctl;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         winc = 1'b0;
    logic         rinc = 1'b0;
    logic [W-1:0] wdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_ctl_if #(.WIDTH(W), .ADDR_W(2)) if_s4 ();
    sync_fifo_ctl_if #(.WIDTH(W), .ADDR_W(3)) if_s5 ();
    sync_fifo_ctl_if #(.WIDTH(W), .ADDR_W(2)) if_f4 ();

    assign if_s4.winc = winc;  assign if_s4.rinc = rinc;  assign if_s4.wdata = wdata;
    assign if_s5.winc = winc;  assign if_s5.rinc = rinc;  assign if_s5.wdata = wdata;
    assign if_f4.winc = winc;  assign if_f4.rinc = rinc;  assign if_f4.wdata = wdata;

    sync_fifo_ctl #(.WIDTH(W), .DEPTH(4), .ADDR_W(2), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1))
        u_s4 (.clk(clk), .rst(rst), .clr(clr), .bus(if_s4));
    sync_fifo_ctl #(.WIDTH(W), .DEPTH(5), .ADDR_W(3), .FWFT(0), .AFULL_TH(4), .AEMPTY_TH(2))
        u_s5 (.clk(clk), .rst(rst), .clr(clr), .bus(if_s5));
    sync_fifo_ctl #(.WIDTH(W), .DEPTH(4), .ADDR_W(2), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1))
        u_f4 (.clk(clk), .rst(rst), .clr(clr), .bus(if_f4));

    // Reference model: contents as a queue, plus sticky flags and the last popped word.
    typedef struct {
        int           depth;
        int           afth;
        int           aeth;
        bit           ovf;
        bit           udf;
        bit           rv;
        logic [W-1:0] rd;
    } model_t;

    model_t       ms [2];
    logic [W-1:0] mq0 [$];
    logic [W-1:0] mq1 [$];

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int k = 0; k < 2; k++) begin
            ms[k].ovf = 1'b0;
            ms[k].udf = 1'b0;
            ms[k].rv  = 1'b0;
            ms[k].rd  = '0;
        end
    endtask

    task automatic model_edge(input int k, input bit w, input bit r, input logic [W-1:0] d, input bit c);
        logic [W-1:0] q [$];
        bit full_now, empty_now;
        if (k == 0) q = mq0; else q = mq1;
        if (c) begin
            q.delete();
            ms[k].ovf = 1'b0;
            ms[k].udf = 1'b0;
            ms[k].rv  = 1'b0;
            ms[k].rd  = '0;
        end else begin
            full_now  = (q.size() == ms[k].depth);
            empty_now = (q.size() == 0);
            ms[k].rv  = 1'b0;
            if (r) begin
                if (empty_now) ms[k].udf = 1'b1;
                else begin
                    ms[k].rd = q.pop_front();
                    ms[k].rv = 1'b1;
                end
            end
            if (w) begin
                if (full_now) ms[k].ovf = 1'b1;
                else q.push_back(d);
            end
        end
        if (k == 0) mq0 = q; else mq1 = q;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_group(input string tag, input int k, input bit fwft, input int cnt,
                               input logic wf, input logic waf, input logic re, input logic rae,
                               input logic ov, input logic un, input logic rv, input logic [W-1:0] rd);
        int           n;
        logic [W-1:0] head;
        n    = (k == 0) ? mq0.size() : mq1.size();
        head = '0;
        if (n > 0) head = (k == 0) ? mq0[0] : mq1[0];
        check({tag, ".count"},     W'(cnt), W'(n));
        check({tag, ".wfull"},     W'(wf),  W'(n == ms[k].depth));
        check({tag, ".wafull"},    W'(waf), W'(n >= ms[k].afth));
        check({tag, ".rempty"},    W'(re),  W'(n == 0));
        check({tag, ".raempty"},   W'(rae), W'(n <= ms[k].aeth));
        check({tag, ".overflow"},  W'(ov),  W'(ms[k].ovf));
        check({tag, ".underflow"}, W'(un),  W'(ms[k].udf));
        if (fwft) begin
            check({tag, ".rvalid"}, W'(rv), W'(n != 0));
            if (n != 0) check({tag, ".rdata"}, rd, head);
        end else begin
            check({tag, ".rvalid"}, W'(rv), W'(ms[k].rv));
            check({tag, ".rdata"},  rd,      ms[k].rd);
        end
    endtask

    task automatic check_all(input string tag);
        check_group({tag, "/s4"}, 0, 1'b0, int'(if_s4.count), if_s4.wfull, if_s4.wafull, if_s4.rempty,
                    if_s4.raempty, if_s4.overflow, if_s4.underflow, if_s4.rvalid, if_s4.rdata);
        check_group({tag, "/s5"}, 1, 1'b0, int'(if_s5.count), if_s5.wfull, if_s5.wafull, if_s5.rempty,
                    if_s5.raempty, if_s5.overflow, if_s5.underflow, if_s5.rvalid, if_s5.rdata);
        check_group({tag, "/f4"}, 0, 1'b1, int'(if_f4.count), if_f4.wfull, if_f4.wafull, if_f4.rempty,
                    if_f4.raempty, if_f4.overflow, if_f4.underflow, if_f4.rvalid, if_f4.rdata);
    endtask

    // One clock cycle: drive at the falling edge, model the rising edge, check at the next falling edge.
    task automatic tick(input bit w, input bit r, input logic [W-1:0] d, input bit c, input string tag);
        winc  = w;
        rinc  = r;
        wdata = d;
        clr   = c;
        @(posedge clk);
        model_edge(0, w, r, d, c);
        model_edge(1, w, r, d, c);
        @(negedge clk);
        winc = 1'b0;
        rinc = 1'b0;
        clr  = 1'b0;
        check_all(tag);
    endtask

    initial begin
        ms[0].depth = 4; ms[0].afth = 3; ms[0].aeth = 1;
        ms[1].depth = 5; ms[1].afth = 4; ms[1].aeth = 2;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Fill / drain
        for (int i = 1; i <= 4; i++) tick(1'b1, 1'b0, W'(i), 1'b0, "fill");
        check("fill/s4.wfull_lit", W'(if_s4.wfull), W'(1));
        check("fill/s4.count_lit", W'(if_s4.count), W'(4));
        for (int i = 1; i <= 4; i++) begin
            tick(1'b0, 1'b1, '0, 1'b0, "drain");
            check("drain/s4.rdata_lit", if_s4.rdata, W'(i));
        end

        // Full plus simultaneous write and read
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, W'(64'hA0 + i), 1'b0, "fill_abcd");
        tick(1'b1, 1'b1, W'(64'hEE), 1'b0, "full_both");
        check("full_both/s4.rdata_lit", if_s4.rdata, W'(64'hA0));
        check("full_both/s4.overflow_lit", W'(if_s4.overflow), W'(1));
        tick(1'b0, 1'b0, '0, 1'b0, "ovf_sticky");
        tick(1'b0, 1'b0, '0, 1'b1, "clr_after_full");

        // Empty plus simultaneous write and read
        tick(1'b1, 1'b1, W'(64'h55), 1'b0, "empty_both");
        check("empty_both/f4.rdata_lit", if_f4.rdata, W'(64'h55));
        check("empty_both/s4.underflow_lit", W'(if_s4.underflow), W'(1));
        tick(1'b0, 1'b0, '0, 1'b1, "clr_after_empty");

        // FWFT streaming: prime one word, then write and read every cycle
        tick(1'b1, 1'b0, W'({$urandom, $urandom}), 1'b0, "stream_prime");
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b1, W'({$urandom, $urandom}), 1'b0, "stream");
            check("stream/f4.rempty_lit", W'(if_f4.rempty), W'(0));
        end
        tick(1'b0, 1'b0, '0, 1'b1, "clr_after_stream");

        // Interleaved pairs to exercise the depth-5 wrap
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, W'(64'h500 + i), 1'b0, "wrap_w");
            tick(1'b1, 1'b1, W'(64'h600 + i), 1'b0, "wrap_wr");
        end
        tick(1'b0, 1'b0, '0, 1'b1, "clr_after_wrap");

        // Mid-stream asynchronous reset with three words held
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, W'(64'h300 + i), 1'b0, "pre_rst");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst/s4.count_lit", W'(if_s4.count), W'(0));
        @(negedge clk);
        check_all("rst_hold");
        rst = 1'b0;
        tick(1'b1, 1'b0, W'(64'h77), 1'b0, "post_rst_w");
        tick(1'b0, 1'b1, '0, 1'b0, "post_rst_r");
        check("post_rst/s4.rdata_lit", if_s4.rdata, W'(64'h77));

        // Randomized traffic: write-heavy then read-heavy, with rare flushes
        for (int i = 0; i < 400; i++) begin
            bit w, r, c;
            if (i < 200) begin
                w = ($urandom_range(3) != 0);
                r = ($urandom_range(1) != 0);
            end else begin
                w = ($urandom_range(1) != 0);
                r = ($urandom_range(3) != 0);
            end
            c = ($urandom_range(63) == 0);
            tick(w, r, W'({$urandom, $urandom}), c, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
